// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug RAM dumper: FSM states, beat record,
// default RAM depth, word stride and the wrapping address step.
package dbg_pkg;

    localparam int          BRAM_WORDS_DEF = 4096;
    localparam logic [31:0] WORD_STRIDE    = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } dump_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    // Next word address, wrapping at the end of the RAM byte span.
    function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic [31:0] span);
        logic [31:0] nxt;
        nxt = addr + WORD_STRIDE;
        return (nxt >= span) ? (nxt - span) : nxt;
    endfunction

endpackage

// File: rtl/dump_skid_buf.sv
// Two-entry address+data FIFO with a bypass path: when empty, an arriving beat is
// presented downstream in the same cycle and only stored if it is not taken.
module dump_skid_buf
    import dbg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  beat_t      in_beat,
    input  logic       out_ready,
    output logic       out_valid,
    output beat_t      out_beat,
    output logic [1:0] count
);

    beat_t mem [2];
    logic  rd_ptr;
    logic  wr_ptr;
    logic  push;
    logic  pop;

    assign pop       = (count != 2'd0) && out_ready;
    assign push      = in_valid && !((count == 2'd0) && out_ready);
    assign out_valid = (count != 2'd0) || in_valid;

    // Idle outputs read as zero rather than echoing the RAM bus.
    always_comb begin
        out_beat = '0;
        if (count != 2'd0) begin
            out_beat = mem[rd_ptr];
        end else if (in_valid) begin
            out_beat = in_beat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/debug_ram_dumper.sv
// Streams a window of a 32-bit RAM out of its debug port as a valid/ready beat stream.
// Optional DUMP_CHECKSUM_EN adds a CHECKSUM port with the running sum of accepted data.
module debug_ram_dumper
    import dbg_pkg::*;
#(
    parameter int BRAM_WORDS = BRAM_WORDS_DEF,
    parameter int CNT_W      = 13
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST_N,
    input  logic             START,
    input  logic [31:0]      BASE_ADDR,
    input  logic [CNT_W-1:0] WORD_CNT,
    output logic             BUSY,
    output logic             DONE,
    output logic [31:0]      DBG_A2,
    output logic [3:0]       DBG_WE2,
    input  logic [31:0]      DBG_RD2,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      OUT_ADDR,
    output logic [31:0]      OUT_DATA,
    output logic             OUT_LAST
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [31:0]      CHECKSUM
`endif
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(BRAM_WORDS);
    localparam logic [31:0]      SPAN    = 32'(BRAM_WORDS * 4);

    dump_state_t      state;
    dump_state_t      state_nx;
    logic [CNT_W-1:0] remain;
    logic [CNT_W-1:0] cnt_clamped;
    logic [31:0]      base_aligned;
    logic             inflight;
    logic [31:0]      rd_addr;
    logic             rd_last;
    logic [1:0]       buf_count;
    logic             start_ok;
    logic             start_zero;
    logic             issue;
    logic             accept;
    beat_t            rd_beat;
    beat_t            out_beat;

    assign DBG_WE2      = 4'b0000;
    assign BUSY         = (state != IDLE);
    assign base_aligned = BASE_ADDR & ~32'h3;
    assign cnt_clamped  = (WORD_CNT > MAX_CNT) ? MAX_CNT : WORD_CNT;
    assign start_ok     = START && (state == IDLE) && (WORD_CNT != '0);
    assign start_zero   = START && (state == IDLE) && (WORD_CNT == '0);

    // Buffered plus in-flight words must stay below two so every returning read has a slot.
    assign issue  = (state == READ) &&
                    ((buf_count == 2'd0) || ((buf_count == 2'd1) && !inflight));
    assign accept = OUT_VALID && OUT_READY;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = READ;
            READ:    if (issue && (remain == CNT_W'(1))) state_nx = DRAIN;
            DRAIN:   if (accept && OUT_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state    <= IDLE;
            remain   <= '0;
            DBG_A2   <= '0;
            inflight <= 1'b0;
            rd_addr  <= '0;
            rd_last  <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            state    <= state_nx;
            DONE     <= start_zero || (accept && OUT_LAST);
            inflight <= issue;
            if (issue) begin
                rd_addr <= DBG_A2;
                rd_last <= (remain == CNT_W'(1));
            end
            if (start_ok) begin
                DBG_A2 <= base_aligned;
                remain <= cnt_clamped;
            end else if (issue) begin
                DBG_A2 <= step_addr(DBG_A2, SPAN);
                remain <= remain - CNT_W'(1);
            end
        end
    end

    // RAM data lands one cycle after issue; tag it with the address and last flag it was read for.
    assign rd_beat = '{addr: rd_addr, data: DBG_RD2, last: rd_last};

    dump_skid_buf u_skid (
        .clk       (CPU_CLK),
        .rst_n     (CPU_RST_N),
        .in_valid  (inflight),
        .in_beat   (rd_beat),
        .out_ready (OUT_READY),
        .out_valid (OUT_VALID),
        .out_beat  (out_beat),
        .count     (buf_count)
    );

    assign OUT_ADDR = out_beat.addr;
    assign OUT_DATA = out_beat.data;
    assign OUT_LAST = out_beat.last;

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            CHECKSUM <= '0;
        end else if (start_ok || start_zero) begin
            CHECKSUM <= '0;
        end else if (accept) begin
            CHECKSUM <= CHECKSUM + OUT_DATA;
        end
    end
`endif

endmodule

// File: tb/tb_debug_ram_dumper.sv
// Directed bench for debug_ram_dumper: synchronous RAM model, scoreboard of expected beats,
// stall-stability and latency checks. Define DUMP_CHECKSUM_EN to also exercise CHECKSUM.
module tb_debug_ram_dumper;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [12:0] word_cnt = '0;
    logic        busy;
    logic        done;
    logic [31:0] dbg_a2;
    logic [3:0]  dbg_we2;
    logic [31:0] dbg_rd2;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        out_last;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem [4096];

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   beats = 0;
    int   dones = 0;
    int   rise_cyc = -1;
    int   last_acc_cyc = -1;
    int   done_cyc = -1;
    int   start_cyc = 0;
    bit   prev_stall = 1'b0;
    bit   prev_valid = 1'b0;
    exp_t prev_beat;
    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) dbg_rd2 <= mem[dbg_a2[13:2]];

    debug_ram_dumper #(.BRAM_WORDS(4096), .CNT_W(13)) dut (
        .CPU_CLK   (clk),
        .CPU_RST_N (rst_n),
        .START     (start),
        .BASE_ADDR (base_addr),
        .WORD_CNT  (word_cnt),
        .BUSY      (busy),
        .DONE      (done),
        .DBG_A2    (dbg_a2),
        .DBG_WE2   (dbg_we2),
        .DBG_RD2   (dbg_rd2),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_ADDR  (out_addr),
        .OUT_DATA  (out_data),
        .OUT_LAST  (out_last)
`ifdef DUMP_CHECKSUM_EN
        ,
        .CHECKSUM  (checksum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: scoreboard pops, stall stability, DONE and latency bookkeeping.
    task automatic sample();
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            return;
        end
        if (out_valid && !prev_valid) rise_cyc = cyc;
        if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_addr", out_addr, prev_beat.addr);
            check("stall_data", out_data, prev_beat.data);
            check("stall_last", out_last, prev_beat.last);
        end
        if (out_valid && out_ready) begin
            beats++;
            check("beat_expected", (q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("beat_addr", out_addr, e.addr);
                check("beat_data", out_data, e.data);
                check("beat_last", out_last, e.last);
            end
            if (out_last) last_acc_cyc = cyc;
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_beat  = '{addr: out_addr, data: out_data, last: out_last};
        prev_valid = out_valid;
    endtask

    // One clock: monitor at the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_start(input logic [31:0] base, input int cnt, input bit expect_acc);
        logic [31:0] a;
        int n;
        start     = 1'b1;
        base_addr = base;
        word_cnt  = 13'(cnt);
        start_cyc = cyc;
        if (expect_acc) begin
            n = (cnt > 4096) ? 4096 : cnt;
            a = base & ~32'h3;
            for (int i = 0; i < n; i++) begin
                q.push_back('{addr: a, data: mem[a[13:2]], last: (i == n - 1)});
                a = (a + 32'd4) % 32'h4000;
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit stall);
        int d0;
        int i;
        logic [7:0] pat;
        d0  = dones;
        i   = 0;
        pat = 8'b1000_1010;
        while (dones == d0 && i < budget) begin
            if (stall) out_ready = pat[i % 8];
            tick();
            i++;
        end
        out_ready = 1'b1;
        check("done_seen", (dones != d0), 1);
    endtask

    initial begin
        int b0;
        int d0;
        int i;
        for (int k = 0; k < 4096; k++) mem[k] = k;

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_dbg_a2", dbg_a2, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_we", dbg_we2, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Plain 8-word dump, READY high
        b0 = beats;
        do_start(32'h0, 8, 1);
        check("a_busy", busy, 1);
        wait_done(64, 0);
        check("a_beats", beats - b0, 8);
        check("a_first_valid", rise_cyc, start_cyc + 2);
        check("a_done_lat", done_cyc, last_acc_cyc + 1);
        check("a_q_empty", q.size(), 0);
        check("a_busy_idle", busy, 0);
        check("a_we", dbg_we2, 0);
        tick();

        // Same dump under 1010 toggling and 3-cycle stalls
        b0 = beats;
        do_start(32'h0, 8, 1);
        wait_done(128, 1);
        check("b_beats", beats - b0, 8);
        check("b_done_lat", done_cyc, last_acc_cyc + 1);
        check("b_q_empty", q.size(), 0);
        tick();

        // Address wrap at top of RAM, with misaligned base bits ignored
        b0 = beats;
        do_start(32'h3FFB, 4, 1);
        wait_done(64, 0);
        check("c_beats", beats - b0, 4);
        check("c_q_empty", q.size(), 0);
        tick();

        // Zero-length dump
        b0 = beats;
        d0 = dones;
        do_start(32'h40, 0, 1);
        check("z_busy", busy, 0);
        tick();
        check("z_done", dones - d0, 1);
        check("z_done_cyc", done_cyc, start_cyc + 1);
        repeat (4) tick();
        check("z_beats", beats - b0, 0);
        check("z_single_done", dones - d0, 1);

        // START while busy is ignored
        b0 = beats;
        d0 = dones;
        do_start(32'h100, 5, 1);
        check("i_busy", busy, 1);
        start     = 1'b1;
        base_addr = 32'h200;
        word_cnt  = 13'd3;
        tick();
        start = 1'b0;
        wait_done(64, 0);
        repeat (6) tick();
        check("i_beats", beats - b0, 5);
        check("i_dones", dones - d0, 1);
        check("i_q_empty", q.size(), 0);

        // Over-length request clamps to the whole RAM
        b0 = beats;
        do_start(32'h0, 5000, 1);
        wait_done(4300, 0);
        check("k_beats", beats - b0, 4096);
        check("k_q_empty", q.size(), 0);
        tick();

        // Reset in the middle of a dump
        b0 = beats;
        do_start(32'h0, 8, 1);
        i = 0;
        while ((beats - b0) < 3 && i < 64) begin
            tick();
            i++;
        end
        check("r_three_beats", beats - b0, 3);
        rst_n = 1'b0;
        #1;
        check("r_valid", out_valid, 0);
        check("r_busy", busy, 0);
        check("r_done", done, 0);
        check("r_last", out_last, 0);
        check("r_dbg_a2", dbg_a2, 0);
        check("r_out_addr", out_addr, 0);
        check("r_out_data", out_data, 0);
        q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        b0 = beats;
        d0 = dones;
        repeat (20) tick();
        check("r_no_beats", beats - b0, 0);
        check("r_no_done", dones - d0, 0);

`ifdef DUMP_CHECKSUM_EN
        mem[64] = 32'h0000_0010;
        mem[65] = 32'h0000_0020;
        mem[66] = 32'hFFFF_FFF0;
        do_start(32'h100, 3, 1);
        wait_done(32, 0);
        check("cs_sum", checksum, 32'h0000_0020);
        repeat (3) tick();
        check("cs_stable", checksum, 32'h0000_0020);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/debug_ram_dumper.md
DEBUG_RAM_DUMPER -- requirements
Module: debug_ram_dumper

Interface
REQ-001 Parameter BRAM_WORDS, default 4096, SHALL give the RAM depth in 32-bit words.
REQ-002 Parameter CNT_W, default 13, SHALL give the width of WORD_CNT (covers 0..BRAM_WORDS).
REQ-003 CPU_CLK  in  1  SHALL be the single clock; all logic is on the rising edge.
REQ-004 CPU_RST_N  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 START  in  1  SHALL be a one-cycle dump request.
REQ-006 BASE_ADDR  in  32  SHALL be the byte address of the first word, sampled on accepted START.
REQ-007 WORD_CNT  in  CNT_W  SHALL be the number of words to dump, sampled on accepted START.
REQ-008 BUSY  out  1  SHALL be high from the cycle after an accepted START until DONE.
REQ-009 DONE  out  1  SHALL be a one-cycle pulse when the last word has been accepted downstream.
REQ-010 DBG_A2  out  32  SHALL be the byte address presented to the RAM debug port.
REQ-011 DBG_WE2  out  4  SHALL be the debug-port byte write enable, constant 4'b0000.
REQ-012 DBG_RD2  in  32  SHALL be the debug-port read data, valid one cycle after DBG_A2 is sampled.
REQ-013 OUT_VALID, OUT_READY, OUT_ADDR(32), OUT_DATA(32), OUT_LAST: out, in, out, out, out; SHALL form a valid/ready word stream carrying address, data, and a last-word flag.

Function
REQ-014 States SHALL be IDLE, READ, and DRAIN: IDLE->READ on START with WORD_CNT!=0; READ->DRAIN when all reads are issued; DRAIN->IDLE when the buffer is empty and the last beat is accepted.
REQ-015 START SHALL be ignored while BUSY is high.
REQ-016 START with WORD_CNT==0 SHALL produce a DONE pulse in the next cycle, with no beats and BUSY staying low.
REQ-017 BASE_ADDR[1:0] SHALL be forced to 0, and WORD_CNT>BRAM_WORDS SHALL be clamped to BRAM_WORDS.
REQ-018 Read addresses SHALL step by 4 modulo BRAM_WORDS*4, wrapping 0x3FFC->0x0000 at the default depth.
REQ-019 A read SHALL be issued only when buffered plus in-flight words are fewer than 2, so no data is ever lost under backpressure.
REQ-020 With OUT_READY held high, the first OUT_VALID SHALL occur 2 cycles after START, and throughput SHALL be one word per cycle.
REQ-021 Once OUT_VALID is asserted, it and OUT_ADDR/OUT_DATA/OUT_LAST SHALL stay stable until OUT_READY is sampled high.
REQ-022 OUT_LAST SHALL be high only on beat WORD_CNT-1, and DONE SHALL pulse in the cycle after that beat is accepted.
REQ-023 Beats SHALL leave in strictly ascending (wrapped) address order, with OUT_ADDR equal to the address that produced OUT_DATA.

Reset
REQ-024 On CPU_RST_N low, the block SHALL enter IDLE with BUSY=0, DONE=0, OUT_VALID=0, OUT_LAST=0, DBG_A2=0, OUT_ADDR=0, OUT_DATA=0, and counters and buffer cleared.
REQ-025 A reset mid-dump SHALL discard in-flight reads and buffered beats, and no beat or DONE SHALL appear after release without a new START.

Configuration
REQ-026 With DUMP_CHECKSUM_EN defined, a CHECKSUM out 32 port SHALL exist, holding the mod-2^32 sum of OUT_DATA over accepted beats of the current dump, cleared on accepted START and stable from DONE until the next START.
REQ-027 Without DUMP_CHECKSUM_EN, the CHECKSUM port and its adder SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 The state enum, the default BRAM_WORDS, and the word-stride constant (4) SHALL live in the shared package dbg_pkg.
REQ-029 The 2-entry address+data buffer SHALL be the sub-module dump_skid_buf; the FSM, counters, and checksum SHALL stay in the top module.

Verification
REQ-030 RAM preloaded with word i = i; START with BASE=0, CNT=8, READY=1 -> 8 beats with data 0..7 and addr 0x00..0x1C, LAST on beat 7, DONE 1 cycle later, first VALID at START+2.
REQ-031 Same preload with READY toggling 1010... and 3-cycle stalls -> same 8 beats in order, no duplicates or drops, outputs stable during stalls.
REQ-032 BASE=0x3FF8, CNT=4 at default depth -> addresses 0x3FF8, 0x3FFC, 0x0000, 0x0004.
REQ-033 CNT=0 -> DONE 1 cycle after START, no VALID; a START during BUSY -> ignored, with the beat count unchanged.
REQ-034 CPU_RST_N pulsed low after beat 3 of 8 -> all outputs at reset values immediately, and no further beats or DONE.
REQ-035 With DUMP_CHECKSUM_EN, words 0x10, 0x20, 0xFFFFFFF0, CNT=3 -> CHECKSUM=0x00000020 at DONE.
